// File: rtl/sdram_bridge_pkg.sv
// Shared types for the SDRAM host bridge: address width, FSM states and the
// posted-write FIFO entry layout.
package sdram_bridge_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_GAP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

endpackage

// File: rtl/sdram_wr_fifo.sv
// Posted-write FIFO of {addr,data}; power-of-two depth so the pointers wrap
// naturally, with a separate occupancy count for the full/empty decision.
module sdram_wr_fifo
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  wr_entry_t       push_data,
    input  logic            pop,
    output wr_entry_t       head,
    output logic [PTR_W:0]  count,
    output logic            full
);

    wr_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sdram_host_bridge.sv
// Host-side bridge to the toggle-handshake SDRAM controller: posted writes
// through a FIFO, single outstanding read with a one-entry read cache.
module sdram_host_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned RD_GAP     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_full,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] sd_waddr,
    output logic [DATA_W-1:0] sd_din,
    output logic              sd_we,
    input  logic              sd_we_ack,
    output logic [ADDR_W-1:0] sd_raddr,
    output logic              sd_rd,
    input  logic              sd_rd_rdy,
    input  logic [DATA_W-1:0] sd_dout
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned GAP_W = (RD_GAP < 1) ? 1 : $clog2(RD_GAP + 1);

    state_t            state_q;
    logic              rd_busy_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] sd_waddr_q;
    logic [DATA_W-1:0] sd_din_q;
    logic              sd_we_q;
    logic [ADDR_W-1:0] sd_raddr_q;
    logic              sd_rd_q;
    logic              cache_valid_q;
    logic [ADDR_W-1:0] cache_addr_q;
    logic [DATA_W-1:0] cache_data_q;
    logic [GAP_W-1:0]  gap_q;
    logic              boot_gap_q;

    wr_entry_t         fifo_push_data;
    wr_entry_t         fifo_head;
    logic [PTR_W:0]    fifo_count;
    logic              fifo_full;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              cache_hit;
    logic              push_hits_cache;
    logic              push_hits_fill;

    assign fifo_empty      = (fifo_count == '0);
    assign fifo_push       = wr_req && !fifo_full;
    assign fifo_pop        = (state_q == ST_IDLE) && !fifo_empty;
    assign fifo_push_data  = '{addr: wr_addr, data: wr_data};
    assign cache_hit       = cache_valid_q && (cache_addr_q == rd_addr_q);
    assign push_hits_cache = fifo_push && (wr_addr == cache_addr_q);
    assign push_hits_fill  = fifo_push && (wr_addr == rd_addr_q);

    sdram_wr_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            rd_busy_q     <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_addr_q     <= '0;
            sd_waddr_q    <= '0;
            sd_din_q      <= '0;
            // Track the controller's toggle so an interrupted write is not replayed.
            sd_we_q       <= sd_we_ack;
            sd_raddr_q    <= '0;
            sd_rd_q       <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
            cache_data_q  <= '0;
            gap_q         <= '0;
            boot_gap_q    <= 1'b1;
        end else begin
            rd_valid_q <= 1'b0;

            if (rd_req && !rd_busy_q) begin
                rd_addr_q <= rd_addr;
                rd_busy_q <= 1'b1;
            end

            if (push_hits_cache) begin
                cache_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        sd_waddr_q <= fifo_head.addr;
                        sd_din_q   <= fifo_head.data;
                        sd_we_q    <= ~sd_we_q;
                        state_q    <= ST_WR_WAIT;
                    end else if (rd_busy_q) begin
                        if (cache_hit) begin
                            rd_data_q  <= cache_data_q;
                            rd_valid_q <= 1'b1;
                            rd_busy_q  <= 1'b0;
                        end else if (boot_gap_q) begin
                            // A read aborted by reset may still be in flight at the controller.
                            boot_gap_q <= 1'b0;
                            gap_q      <= GAP_W'(RD_GAP);
                            state_q    <= ST_GAP;
                        end else begin
                            sd_raddr_q <= rd_addr_q;
                            sd_rd_q    <= 1'b1;
                            state_q    <= ST_RD_REQ;
                        end
                    end
                end
                ST_WR_WAIT: begin
                    if (sd_we_ack == sd_we_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RD_REQ: begin
                    if (!sd_rd_rdy) begin
                        sd_rd_q <= 1'b0;
                        state_q <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (sd_rd_rdy) begin
                        rd_data_q     <= sd_dout;
                        cache_data_q  <= sd_dout;
                        cache_addr_q  <= rd_addr_q;
                        // A write to the same address queued this cycle makes the fill stale.
                        cache_valid_q <= !push_hits_fill;
                        rd_valid_q    <= 1'b1;
                        rd_busy_q     <= 1'b0;
                        gap_q         <= GAP_W'(RD_GAP);
                        state_q       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_q <= GAP_W'(1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q - 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_full  = fifo_full;
    assign rd_busy  = rd_busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign sd_waddr = sd_waddr_q;
    assign sd_din   = sd_din_q;
    assign sd_we    = sd_we_q;
    assign sd_raddr = sd_raddr_q;
    assign sd_rd    = sd_rd_q;

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Scoreboard bench for sdram_host_bridge with a toggle-handshake SDRAM
// controller model (write ack and read latency) driven on the falling edge.
module tb_sdram_host_bridge;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_GAP     = 8;

    logic        clk;
    logic        reset;
    logic        wr_req;
    logic [24:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_full;
    logic        rd_req;
    logic [24:0] rd_addr;
    logic        rd_busy;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic [24:0] sd_waddr;
    logic [7:0]  sd_din;
    logic        sd_we;
    logic        sd_we_ack;
    logic [24:0] sd_raddr;
    logic        sd_rd;
    logic        sd_rd_rdy;
    logic [7:0]  sd_dout;

    sdram_host_bridge #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_GAP     (RD_GAP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .sd_waddr  (sd_waddr),
        .sd_din    (sd_din),
        .sd_we     (sd_we),
        .sd_we_ack (sd_we_ack),
        .sd_raddr  (sd_raddr),
        .sd_rd     (sd_rd),
        .sd_rd_rdy (sd_rd_rdy),
        .sd_dout   (sd_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] addr;
        logic [7:0]  data;
    } wr_t;

    int          checks;
    int          failures;
    wr_t         exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  mem [logic [24:0]];
    bit          ack_stall;
    int          ack_wait;
    int          rd_lat;
    bit          rd_inflight;
    logic        rd_prev;
    logic        we_prev;
    logic [24:0] model_raddr;
    int          n_issue;
    int          n_ack;
    int          n_rd_rise;
    int          n_valid;
    wr_t         mon_e;
    logic [7:0]  mon_d;

    // Monitors first (observe the outputs of the last rising edge), then the controller model.
    always @(negedge clk) begin
        if (reset === 1'b0 && sd_we !== we_prev) begin
            n_issue++;
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL wr_issue unexpected write addr=%h data=%h", sd_waddr, sd_din);
            end else begin
                mon_e = exp_wr.pop_front();
                if (sd_waddr !== mon_e.addr || sd_din !== mon_e.data) begin
                    failures++;
                    $display("FAIL wr_issue got addr=%h data=%h expected addr=%h data=%h",
                             sd_waddr, sd_din, mon_e.addr, mon_e.data);
                end
            end
            checks++;
            if (we_prev !== sd_we_ack) begin
                failures++;
                $display("FAIL wr_overlap issued before previous ack: ack=%b prev_we=%b", sd_we_ack, we_prev);
            end
        end
        we_prev = sd_we;

        if (rd_valid === 1'b1) begin
            n_valid++;
            checks++;
            if (exp_rd.size() == 0) begin
                failures++;
                $display("FAIL rd_valid unexpected pulse data=%h", rd_data);
            end else begin
                mon_d = exp_rd.pop_front();
                if (rd_data !== mon_d) begin
                    failures++;
                    $display("FAIL rd_data got=%h expected=%h", rd_data, mon_d);
                end
            end
        end

        if (sd_rd === 1'b1 && rd_prev !== 1'b1) begin
            n_rd_rise++;
            sd_rd_rdy   = 1'b0;
            rd_lat      = 3;
            model_raddr = sd_raddr;
            rd_inflight = 1'b1;
        end else if (rd_inflight) begin
            if (rd_lat <= 1) begin
                sd_dout     = mem.exists(model_raddr) ? mem[model_raddr] : 8'h00;
                sd_rd_rdy   = 1'b1;
                rd_inflight = 1'b0;
            end else begin
                rd_lat--;
            end
        end
        rd_prev = sd_rd;

        if (sd_we !== sd_we_ack && !ack_stall && reset === 1'b0) begin
            if (ack_wait >= 2) begin
                mem[sd_waddr] = sd_din;
                sd_we_ack     = sd_we;
                n_ack++;
                ack_wait      = 0;
            end else begin
                ack_wait++;
            end
        end else begin
            ack_wait = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int i;
        i = 0;
        while (i < 1000 && (exp_wr.size() != 0 || exp_rd.size() != 0 ||
                            rd_busy !== 1'b0 || sd_we !== sd_we_ack)) begin
            tick();
            i++;
        end
        checks++;
        if (i >= 1000) begin
            failures++;
            $display("FAIL %s_drain timeout wr_left=%0d rd_left=%0d rd_busy=%b", nm,
                     exp_wr.size(), exp_rd.size(), rd_busy);
        end
    endtask

    task automatic issue_read(input logic [24:0] a);
        int i;
        i = 0;
        while (i < 200 && rd_busy !== 1'b0) begin
            tick();
            i++;
        end
        rd_req  = 1'b1;
        rd_addr = a;
        tick();
        rd_req  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        checks += 10;
        if (wr_full !== 1'b0)       begin failures++; $display("FAIL reset_wr_full got=%b expected=0", wr_full); end
        if (rd_busy !== 1'b0)       begin failures++; $display("FAIL reset_rd_busy got=%b expected=0", rd_busy); end
        if (rd_valid !== 1'b0)      begin failures++; $display("FAIL reset_rd_valid got=%b expected=0", rd_valid); end
        if (rd_data !== 8'h00)      begin failures++; $display("FAIL reset_rd_data got=%h expected=00", rd_data); end
        if (sd_rd !== 1'b0)         begin failures++; $display("FAIL reset_sd_rd got=%b expected=0", sd_rd); end
        if (sd_raddr !== 25'h0)     begin failures++; $display("FAIL reset_sd_raddr got=%h expected=0", sd_raddr); end
        if (sd_waddr !== 25'h0)     begin failures++; $display("FAIL reset_sd_waddr got=%h expected=0", sd_waddr); end
        if (sd_din !== 8'h00)       begin failures++; $display("FAIL reset_sd_din got=%h expected=00", sd_din); end
        if (sd_we !== 1'b1)         begin failures++; $display("FAIL reset_sd_we got=%b expected=1 (ack)", sd_we); end
        tick();
        if (sd_we !== 1'b1)         begin failures++; $display("FAIL reset_no_phantom sd_we=%b expected=1", sd_we); end
    endtask

    task automatic test_write_order();
        int i0;
        int a0;
        logic [7:0] d [3];
        d[0] = 8'hA1; d[1] = 8'hA2; d[2] = 8'hA3;
        i0 = n_issue;
        a0 = n_ack;
        for (int i = 0; i < 3; i++) begin
            wr_req  = 1'b1;
            wr_addr = 25'h00010 + 25'(i);
            wr_data = d[i];
            exp_wr.push_back('{addr: wr_addr, data: wr_data});
            tick();
        end
        wr_req = 1'b0;
        drain("write_order");
        checks++;
        if (n_issue - i0 != 3 || n_ack - a0 != 3) begin
            failures++;
            $display("FAIL write_order_count issues=%0d acks=%0d expected=3", n_issue - i0, n_ack - a0);
        end
    endtask

    task automatic test_back_to_back();
        int i0;
        int w;
        i0 = n_issue;
        ack_stall = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 25'h000F0;
        wr_data = 8'hC0;
        exp_wr.push_back('{addr: wr_addr, data: wr_data});
        tick();
        wr_req = 1'b0;
        w = 0;
        while (w < 50 && sd_we === sd_we_ack) begin
            tick();
            w++;
        end
        checks++;
        if (sd_we === sd_we_ack) begin
            failures++;
            $display("FAIL b2b_first_issue timeout sd_we=%b ack=%b", sd_we, sd_we_ack);
        end
        for (int i = 0; i < 5; i++) begin
            wr_req  = 1'b1;
            wr_addr = 25'h00100 + 25'(i);
            wr_data = 8'hB0 + 8'(i);
            if (i < FIFO_DEPTH) exp_wr.push_back('{addr: wr_addr, data: wr_data});
            tick();
            if (i == 2) begin
                checks++;
                if (wr_full !== 1'b0) begin failures++; $display("FAIL b2b_not_full got=%b expected=0", wr_full); end
            end
            if (i == 3) begin
                checks++;
                if (wr_full !== 1'b1) begin failures++; $display("FAIL b2b_full got=%b expected=1", wr_full); end
            end
        end
        wr_req = 1'b0;
        checks++;
        if (wr_full !== 1'b1) begin failures++; $display("FAIL b2b_full_hold got=%b expected=1", wr_full); end
        ack_stall = 1'b0;
        drain("back_to_back");
        checks++;
        if (n_issue - i0 != 5) begin
            failures++;
            $display("FAIL b2b_issue_count got=%0d expected=5", n_issue - i0);
        end
        checks++;
        if (wr_full !== 1'b0) begin failures++; $display("FAIL b2b_full_clear got=%b expected=0", wr_full); end
    endtask

    task automatic test_read_after_writes();
        int a0;
        int w;
        a0 = n_ack;
        wr_req = 1'b1; wr_addr = 25'h00020; wr_data = 8'h11;
        exp_wr.push_back('{addr: wr_addr, data: wr_data});
        tick();
        wr_addr = 25'h00021; wr_data = 8'h22;
        exp_wr.push_back('{addr: wr_addr, data: wr_data});
        tick();
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 25'h01234;
        exp_rd.push_back(8'h5A);
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_busy !== 1'b1) begin failures++; $display("FAIL rd_busy_latch got=%b expected=1", rd_busy); end
        w = 0;
        while (w < 300 && sd_rd !== 1'b1) begin
            tick();
            w++;
        end
        checks++;
        if (sd_rd !== 1'b1 || n_ack - a0 != 2) begin
            failures++;
            $display("FAIL rd_after_writes sd_rd=%b acks_before_rd=%0d expected sd_rd=1 acks=2", sd_rd, n_ack - a0);
        end
        checks++;
        if (sd_raddr !== 25'h01234) begin failures++; $display("FAIL rd_addr got=%h expected=01234", sd_raddr); end
        drain("read_after_writes");
    endtask

    task automatic test_cache_hit();
        int r0;
        repeat (RD_GAP + 2) tick();
        r0 = n_rd_rise;
        rd_req  = 1'b1;
        rd_addr = 25'h01234;
        exp_rd.push_back(8'h5A);
        tick();
        rd_req = 1'b0;
        checks++;
        if (rd_busy !== 1'b1 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL hit_latch rd_busy=%b rd_valid=%b expected 1/0", rd_busy, rd_valid);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
            failures++;
            $display("FAIL hit_timing rd_valid=%b rd_data=%h expected 1/5a", rd_valid, rd_data);
        end
        drain("cache_hit");
        checks++;
        if (n_rd_rise != r0) begin failures++; $display("FAIL hit_no_sdram rises=%0d expected=0", n_rd_rise - r0); end
        tick();
        checks++;
        if (rd_data !== 8'h5A) begin failures++; $display("FAIL hit_rd_data_hold got=%h expected=5a", rd_data); end
    endtask

    task automatic test_cache_invalidate();
        int r0;
        exp_rd.push_back(8'h5A);
        issue_read(25'h01234);
        drain("inval_first");
        r0 = n_rd_rise;
        wr_req  = 1'b1;
        wr_addr = 25'h01234;
        wr_data = 8'h77;
        exp_wr.push_back('{addr: wr_addr, data: wr_data});
        tick();
        wr_req = 1'b0;
        exp_rd.push_back(8'h77);
        issue_read(25'h01234);
        drain("cache_invalidate");
        checks++;
        if (n_rd_rise - r0 != 1) begin
            failures++;
            $display("FAIL inval_sdram_read rises=%0d expected=1", n_rd_rise - r0);
        end
    endtask

    task automatic test_reset_in_write();
        int i0;
        int w;
        repeat (RD_GAP + 2) tick();
        ack_stall = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 25'h00300;
        wr_data = 8'hE5;
        exp_wr.push_back('{addr: wr_addr, data: wr_data});
        tick();
        wr_req = 1'b0;
        w = 0;
        while (w < 50 && sd_we === sd_we_ack) begin
            tick();
            w++;
        end
        checks++;
        if (sd_we === sd_we_ack) begin failures++; $display("FAIL rstwr_issue timeout"); end
        tick();
        i0 = n_issue;
        reset = 1'b1;
        repeat (2) tick();
        sd_we_ack = ~sd_we_ack;
        repeat (2) tick();
        reset = 1'b0;
        checks++;
        if (sd_we !== sd_we_ack) begin
            failures++;
            $display("FAIL rstwr_we_match sd_we=%b ack=%b", sd_we, sd_we_ack);
        end
        ack_stall = 1'b0;
        repeat (12) tick();
        checks++;
        if (n_issue != i0 || sd_we !== sd_we_ack) begin
            failures++;
            $display("FAIL rstwr_no_extra issues=%0d expected=0 sd_we=%b ack=%b", n_issue - i0, sd_we, sd_we_ack);
        end
    endtask

    task automatic test_reset_mid_read();
        int v0;
        int w;
        issue_read(25'h00500);
        w = 0;
        while (w < 100 && sd_rd !== 1'b1) begin
            tick();
            w++;
        end
        checks++;
        if (sd_rd !== 1'b1) begin failures++; $display("FAIL rstrd_issue timeout"); end
        tick();
        v0 = n_valid;
        reset = 1'b1;
        tick();
        checks++;
        if (sd_rd !== 1'b0 || rd_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstrd_drop sd_rd=%b rd_busy=%b expected 0/0", sd_rd, rd_busy);
        end
        tick();
        reset = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_valid != v0) begin failures++; $display("FAIL rstrd_no_valid pulses=%0d expected=0", n_valid - v0); end
        exp_rd.push_back(8'h77);
        rd_req  = 1'b1;
        rd_addr = 25'h01234;
        tick();
        rd_req = 1'b0;
        w = 1;
        while (w < 100 && sd_rd !== 1'b1) begin
            tick();
            w++;
        end
        checks++;
        if (sd_rd !== 1'b1 || w <= RD_GAP) begin
            failures++;
            $display("FAIL rstrd_gap cycles_to_issue=%0d required>%0d sd_rd=%b", w, RD_GAP, sd_rd);
        end
        drain("reset_mid_read");
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        reset       = 1'b1;
        wr_req      = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        rd_req      = 1'b0;
        rd_addr     = '0;
        sd_we_ack   = 1'b1;
        sd_rd_rdy   = 1'b1;
        sd_dout     = 8'h00;
        ack_stall   = 1'b0;
        ack_wait    = 0;
        rd_lat      = 0;
        rd_inflight = 1'b0;
        rd_prev     = 1'b0;
        we_prev     = 1'b1;
        model_raddr = '0;
        n_issue     = 0;
        n_ack       = 0;
        n_rd_rise   = 0;
        n_valid     = 0;
        mem[25'h01234] = 8'h5A;

        test_reset();
        test_write_order();
        test_back_to_back();
        test_read_after_writes();
        test_cache_hit();
        test_cache_invalidate();
        test_reset_in_write();
        test_reset_mid_read();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdram_host_bridge.md
SDRAM_HOST_BRIDGE -- requirements
Module: sdram_host_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of posted-write entries (power of two, 2..16).
REQ-002 SHALL have parameter RD_GAP, default 8, meaning the minimum number of clocks sd_rd stays low after sd_rd_rdy rises.
REQ-003 clk  in  1  rising-edge clock, same clock as the SDRAM controller.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 wr_req  in  1  one-cycle write strobe (ROM download / cart RAM write).
REQ-006 wr_addr  in  25  byte address of the write.
REQ-007 wr_data  in  8  write byte.
REQ-008 wr_full  out  1  FIFO full; a wr_req while full is dropped.
REQ-009 rd_req  in  1  one-cycle read strobe.
REQ-010 rd_addr  in  25  byte address of the read.
REQ-011 rd_busy  out  1  read in progress; a rd_req while busy is ignored.
REQ-012 rd_valid  out  1  one-cycle pulse; rd_data is valid.
REQ-013 rd_data  out  8  read byte, held until the next rd_valid.
REQ-014 sd_waddr / sd_din  out  25 / 8  controller write address and data.
REQ-015 sd_we  out  1  write toggle; a request is pending while sd_we != sd_we_ack.
REQ-016 sd_we_ack  in  1  controller write acknowledge toggle.
REQ-017 sd_raddr  out  25  controller read address.
REQ-018 sd_rd  out  1  read level; the controller starts on a rising edge.
REQ-019 sd_rd_rdy  in  1  low while a read is accepted and in flight; high when dout is valid.
REQ-020 sd_dout  in  8  controller read byte.

Function
REQ-021 Writes SHALL enter a FIFO of {addr,data} on wr_req && !wr_full; wr_full = (count == FIFO_DEPTH).
REQ-022 FSM states: IDLE, WR_WAIT, RD_REQ, RD_WAIT, GAP.
REQ-023 IDLE with FIFO non-empty: load sd_waddr/sd_din from the FIFO head, toggle sd_we, pop the entry, and go to WR_WAIT.
REQ-024 WR_WAIT: when sd_we_ack == sd_we, go to IDLE.
REQ-025 A read SHALL latch rd_addr and raise rd_busy the cycle after rd_req; it starts only from IDLE with the FIFO empty, so all earlier writes complete first.
REQ-026 Pending-read hit: if cache_valid and the latched address equals cache_addr, rd_data = cache_data and rd_valid pulses one cycle after the latch, with no SDRAM access.
REQ-027 Miss: RD_REQ drives sd_raddr and sd_rd=1 until sd_rd_rdy is sampled low, then drives sd_rd=0 and goes to RD_WAIT.
REQ-028 RD_WAIT: when sd_rd_rdy is high, capture sd_dout into rd_data and the cache, set cache_valid, pulse rd_valid, clear rd_busy, load the gap counter, and go to GAP.
REQ-029 GAP: hold sd_rd low for RD_GAP clocks, then go to IDLE; writes are also held off during GAP.
REQ-030 Priority in IDLE: a non-empty FIFO wins over a pending read, so a read waits behind all queued writes.
REQ-031 Any FIFO push whose address equals cache_addr SHALL clear cache_valid in the same cycle.
REQ-032 Simultaneous push and pop SHALL leave count unchanged; the full condition and the wrap of the pointers are handled correctly.

Reset
REQ-033 Reset values: FIFO empty, wr_full=0, rd_busy=0, rd_valid=0, rd_data=0, sd_rd=0, sd_raddr=0, sd_waddr=0, sd_din=0, cache_valid=0, state IDLE.
REQ-034 On reset, sd_we SHALL be loaded from sd_we_ack rather than 0, so a reset during a write cannot leave a phantom request.
REQ-035 Reset mid-read: sd_rd drops to 0, the result is discarded, rd_valid is not pulsed, and the first read after reset passes through GAP before issue.

Structure
REQ-036 A shared package sdram_bridge_pkg SHALL hold the FSM state enum and the 25-bit address width constant.
REQ-037 The FIFO SHALL be a sub-module sdram_wr_fifo (parameter FIFO_DEPTH), with push, pop, head, count, and full ports.

Verification
REQ-038 Three wr_req to 0x00010..0x00012 with data A1/A2/A3 -> three sd_we toggles in order with matching sd_waddr/sd_din, each waiting for sd_we_ack.
REQ-039 Five back-to-back wr_req with FIFO_DEPTH=4 and sd_we_ack stalled -> wr_full=1 after four; the fifth is dropped; the drained sequence holds 4 entries.
REQ-040 rd_req 0x1234 while 2 writes are queued -> sd_rd rises only after the second we_ack; rd_valid with the byte from the controller model (5A).
REQ-041 Two rd_req to 0x1234 -> the second gives rd_valid one clock after the latch, with sd_rd never rising.
REQ-042 Read 0x1234, then a write of 77 to 0x1234, then a read of 0x1234 -> the cache is invalidated and the second read goes to SDRAM and returns 77.
REQ-043 Reset asserted in WR_WAIT, then the model toggles we_ack -> after reset sd_we == sd_we_ack, and no extra write is issued.
